// File: rtl/riscv_ifetch.sv
// riscv_ifetch: decoupled fetch with in-flight PC FIFO, fetch queue and flush drop counter.
// Optional IFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module riscv_ifetch #(
  parameter int FQ_DEPTH        = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        x_reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int OW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1) + 1;
  localparam logic [CW-1:0] FQ_D = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] MO_D = CW'(MAX_OUTSTANDING);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t     fq_mem  [FQ_DEPTH];
  logic [31:0]   pcq_mem [MAX_OUTSTANDING];
  logic [AW-1:0] fq_wr, fq_rd;
  logic [OW-1:0] pcq_wr, pcq_rd;
  logic [CW-1:0] fq_count, outstanding, drop_count;

  logic credit, issue, fq_empty;
  logic rsp_live, rsp_take, rsp_drop;
  logic fq_push, fq_pop, byp;

  function automatic logic [OW-1:0] pcq_nxt(input logic [OW-1:0] p);
    return (p == OW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fq_empty = (fq_count == '0);
  assign credit   = ((fq_count + outstanding) < FQ_D)
                  && (outstanding < MO_D);

  assign imem_req_valid = x_reset & pc_valid & credit & ~flush;
  assign pc_ready       = x_reset & imem_req_ready & credit & ~flush;
  assign imem_addr      = pc_in;
  assign issue          = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding are leftovers from before reset.
  assign rsp_live = imem_rsp_valid & (outstanding != '0);
  assign rsp_drop = rsp_live & (flush | (drop_count != '0));
  assign rsp_take = rsp_live & ~flush & (drop_count == '0);

`ifdef IFETCH_BYPASS_EN
  assign byp = rsp_take & fq_empty;
`else
  assign byp = 1'b0;
`endif

  assign fq_pop     = ~fq_empty & ~flush & inst_ready;
  assign fq_push    = rsp_take & ~(byp & inst_ready);
  assign inst_valid = (~fq_empty & ~flush) | byp;

  always_comb begin
    inst    = NOP;
    inst_pc = '0;
    if (!fq_empty) begin
      inst    = fq_mem[fq_rd].data;
      inst_pc = fq_mem[fq_rd].pc;
    end else if (byp) begin
      inst    = imem_rsp_data;
      inst_pc = pcq_mem[pcq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (fq_push) fq_mem[fq_wr] <= '{data: imem_rsp_data, pc: pcq_mem[pcq_rd]};
    if (issue)   pcq_mem[pcq_wr] <= pc_in;
  end

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_count    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      outstanding <= '0;
      drop_count  <= '0;
    end else if (flush) begin
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_count    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      outstanding <= outstanding - CW'(rsp_live);
      drop_count  <= outstanding - CW'(rsp_live);
    end else begin
      if (fq_push) fq_wr <= fq_wr + 1'b1;
      if (fq_pop)  fq_rd <= fq_rd + 1'b1;
      fq_count <= fq_count + CW'(fq_push) - CW'(fq_pop);
      if (issue)    pcq_wr <= pcq_nxt(pcq_wr);
      if (rsp_take) pcq_rd <= pcq_nxt(pcq_rd);
      outstanding <= outstanding + CW'(issue) - CW'(rsp_live);
      if (rsp_drop) drop_count <= drop_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// tb_riscv_ifetch: scoreboard bench for riscv_ifetch with an in-order memory model.
// Honors IFETCH_BYPASS_EN for the expected response-to-inst latency.
module tb_riscv_ifetch;

  logic        clk;
  logic        x_reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  riscv_ifetch dut (
    .clk            (clk),
    .x_reset        (x_reset),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

`ifdef IFETCH_BYPASS_EN
  localparam int RSP_TO_INST = 0;
`else
  localparam int RSP_TO_INST = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          due_q[$];
  int          rcyc[$];
  int          dcyc[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_req = 0;
  int          n_deliv = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // In-order memory: response visible lat cycles after the request cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (due_q.size() != 0 && due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(addr_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (x_reset && imem_req_valid && imem_req_ready) begin
      addr_q.push_back(imem_addr);
      due_q.push_back(cyc + lat);
      rcyc.push_back(cyc);
      n_req++;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (x_reset && inst_valid && inst_ready) begin
      exp_t e;
      n_deliv++;
      dcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h, required none",
                 inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pcs(input logic [31:0] base, input int n,
                           input int max_cyc, output int sent);
    logic acc;
    int   c;
    sent = 0;
    c    = 0;
    while (sent < n && c < max_cyc) begin
      pc_in    = base + 32'(4 * sent);
      pc_valid = 1'b1;
      @(negedge clk);
      acc = pc_ready;
      if (acc) exp_q.push_back('{pc: pc_in, data: memword(pc_in)});
      step();
      if (acc) sent++;
      c++;
    end
    pc_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 60) begin
      step();
      c++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int r0;
    int rc;
    int vc;
    x_reset        = 1'b0;
    pc_in          = 32'h0;
    pc_valid       = 1'b1;
    flush          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b1;

    #2;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_pc_ready", 32'(pc_ready), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (3) step();
    pc_valid = 1'b0;
    x_reset  = 1'b1;
    step();

    // Two sequential fetches, 1-cycle memory.
    rcyc.delete();
    dcyc.delete();
    drive_pcs(32'h0, 2, 20, sent);
    wait_empty("t1_drain");
    if (rcyc.size() >= 1 && dcyc.size() >= 2) begin
      check("t1_latency", 32'(dcyc[0] - rcyc[0]), 32'(1 + RSP_TO_INST));
      check("t1_gap", 32'(dcyc[1] - dcyc[0]), 32'd1);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL t1_count: got %0d deliveries, required 2", dcyc.size());
    end
    repeat (2) step();

    // Decode stalled: credit must cap requests at the queue depth.
    inst_ready = 1'b0;
    r0 = n_req;
    drive_pcs(32'h200, 10, 10, sent);
    check("stall_reqs", 32'(n_req - r0), 32'd2);
    pc_valid = 1'b1;
    @(negedge clk);
    check("stall_pc_ready", 32'(pc_ready), 32'd0);
    step();
    pc_valid   = 1'b0;
    inst_ready = 1'b1;
    wait_empty("stall_drain");
    repeat (2) step();

    // Flush with two requests in flight; stale words must vanish.
    lat = 4;
    drive_pcs(32'h40, 2, 20, sent);
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("flush_inst_valid", 32'(inst_valid), 32'd0);
    step();
    flush = 1'b0;
    dcyc.delete();
    drive_pcs(32'h100, 1, 20, sent);
    wait_empty("flush_drain");
    check("flush_deliveries", 32'(dcyc.size()), 32'd1);
    repeat (3) step();

    // Asynchronous reset mid-stream with a late response in flight.
    inst_ready = 1'b0;
    lat = 1;
    drive_pcs(32'h300, 1, 20, sent);
    lat = 6;
    drive_pcs(32'h304, 1, 20, sent);
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2;
    x_reset = 1'b0;
    #1;
    check("arst_inst_valid", 32'(inst_valid), 32'd0);
    check("arst_inst", inst, 32'h0000_0013);
    check("arst_inst_pc", inst_pc, 32'h0);
    exp_q.delete();
    #3;
    x_reset    = 1'b1;
    inst_ready = 1'b1;
    r0 = n_deliv;
    repeat (10) step();
    check("late_rsp_ignored", 32'(n_deliv - r0), 32'd0);

    // Recovery stream after reset.
    lat = 1;
    drive_pcs(32'h400, 4, 40, sent);
    wait_empty("recover_drain");
    repeat (2) step();

    // Response-to-inst_valid latency from an empty queue.
    drive_pcs(32'h500, 1, 20, sent);
    rc = -1;
    vc = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_rsp_valid && rc < 0) rc = cyc;
      if (inst_valid && vc < 0) vc = cyc;
    end
    check("bypass_latency", 32'(vc - rc), 32'(RSP_TO_INST));
    wait_empty("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
